async_fifo_top: RTL and testbench

ASYNC_FIFO_TOP -- requirements
Module: async_fifo_top

---
 rtl/async_fifo_top.sv | 158 +++++++++++++++
 tb/tb_async_fifo_top.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_top.sv
`default_nettype none
// ============================================================================
//  Module      : async_fifo_top
//  Description : Dual-clock FIFO with Gray-coded pointers crossing domains.
//                Storage is 2^LOG2DEPTH x WIDTH. Write side runs on wclk and
//                read side on rclk. Each Gray pointer is synchronized into the
//                opposite domain before it is compared.
//                full is registered in the wclk domain and empty in the rclk
//                domain. Both flags assert on the causing access. Both
//                deassert late, after the synchronizer latency.
//  Ports       : wclk     - write clock
//                rclk     - read clock (unrelated to wclk)
//                reset_n  - asynchronous active-low reset, both domains
//                wen      - write request (rising wclk)
//                data_in  - write data [WIDTH-1:0]
//                ren      - read request (rising rclk)
//                data_out - registered read data [WIDTH-1:0]
//                full     - no free entry (wclk domain)
//                empty    - no readable entry (rclk domain)
//  Config      : ASYNC_FIFO_SYNC3_EN - when defined, both pointer
//                synchronizers are 3 flops deep instead of 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_top #(
    parameter int WIDTH     = 8,
    parameter int LOG2DEPTH = 5
) (
    input  logic             wclk,
    input  logic             rclk,
    input  logic             reset_n,
    input  logic             wen,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ren,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int c_DEPTH = 1 << LOG2DEPTH;
`ifdef ASYNC_FIFO_SYNC3_EN
    localparam int c_SYNC_STAGES = 3;
`else
    localparam int c_SYNC_STAGES = 2;
`endif
    localparam int c_LAST = c_SYNC_STAGES - 1;

    logic [WIDTH-1:0]   r_mem [c_DEPTH];

    // Write domain
    logic [LOG2DEPTH:0] r_wbin;
    logic [LOG2DEPTH:0] r_wgray;
    logic [LOG2DEPTH:0] w_wbin_next;
    logic [LOG2DEPTH:0] w_wgray_next;
    logic [LOG2DEPTH:0] r_rgray_sync [c_SYNC_STAGES];
    logic [LOG2DEPTH:0] w_rgray_full_cmp;
    logic               w_wr_accept;
    logic               r_full;

    // Read domain
    logic [LOG2DEPTH:0] r_rbin;
    logic [LOG2DEPTH:0] r_rgray;
    logic [LOG2DEPTH:0] w_rbin_next;
    logic [LOG2DEPTH:0] w_rgray_next;
    logic [LOG2DEPTH:0] r_wgray_sync [c_SYNC_STAGES];
    logic               w_rd_accept;
    logic               r_empty;
    logic [WIDTH-1:0]   r_data_out;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign w_wr_accept  = wen & ~r_full;
    assign w_wbin_next  = r_wbin + {{LOG2DEPTH{1'b0}}, w_wr_accept};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // When the writer is exactly one lap ahead, its Gray pointer matches the
    // reader's with the two MSBs flipped. This comes from the reflected
    // property of the extra wrap bit.
    assign w_rgray_full_cmp = {~r_rgray_sync[c_LAST][LOG2DEPTH:LOG2DEPTH-1],
                               r_rgray_sync[c_LAST][LOG2DEPTH-2:0]};

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= (w_wgray_next == w_rgray_full_cmp);
        end
    end

    // The storage array is deliberately left without a reset. The pointers
    // alone decide which entries are valid.
    always_ff @(posedge wclk) begin
        if (w_wr_accept) begin
            r_mem[r_wbin[LOG2DEPTH-1:0]] <= data_in;
        end
    end

    // Read Gray pointer into the wclk domain
    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_SYNC_STAGES; i++) begin
                r_rgray_sync[i] <= '0;
            end
        end else begin
            r_rgray_sync[0] <= r_rgray;
            for (int i = 1; i < c_SYNC_STAGES; i++) begin
                r_rgray_sync[i] <= r_rgray_sync[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    assign w_rd_accept  = ren & ~r_empty;
    assign w_rbin_next  = r_rbin + {{LOG2DEPTH{1'b0}}, w_rd_accept};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    always_ff @(posedge rclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rbin     <= '0;
            r_rgray    <= '0;
            r_empty    <= 1'b1;
            r_data_out <= '0;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= (w_rgray_next == r_wgray_sync[c_LAST]);
            if (w_rd_accept) begin
                r_data_out <= r_mem[r_rbin[LOG2DEPTH-1:0]];
            end
        end
    end

    // Write Gray pointer into the rclk domain
    always_ff @(posedge rclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_SYNC_STAGES; i++) begin
                r_wgray_sync[i] <= '0;
            end
        end else begin
            r_wgray_sync[0] <= r_wgray;
            for (int i = 1; i < c_SYNC_STAGES; i++) begin
                r_wgray_sync[i] <= r_wgray_sync[i-1];
            end
        end
    end

    assign data_out = r_data_out;
    assign full     = r_full;
    assign empty    = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_top.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module      : tb_async_fifo_top
//  Description : Directed self-checking bench for async_fifo_top. It covers
//                reset, fill to full, overflow, drain to empty, streaming with
//                a fast reader, streaming with a fast writer, and a
//                mid-stream reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_top;

    localparam int WIDTH     = 8;
    localparam int LOG2DEPTH = 5;

    logic             wclk     = 1'b0;
    logic             rclk     = 1'b0;
    logic             reset_n  = 1'b1;
    logic             wen      = 1'b0;
    logic             ren      = 1'b0;
    logic [WIDTH-1:0] data_in  = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    real whalf    = 5.0;
    real rhalf    = 5.0;
    bit  rclk_run = 1'b0;

    int n_pass   = 0;
    int n_checks = 0;

    // Stream state shared by the writer and reader tasks
    logic [7:0] wval;
    logic [7:0] rexp;
    bit         wdone;
    bit         seen_full;
    bit         seen_empty_hi;
    bit         seen_empty_lo;

    async_fifo_top #(
        .WIDTH     (WIDTH),
        .LOG2DEPTH (LOG2DEPTH)
    ) dut (
        .wclk     (wclk),
        .rclk     (rclk),
        .reset_n  (reset_n),
        .wen      (wen),
        .data_in  (data_in),
        .ren      (ren),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #(whalf) wclk = ~wclk;

    always begin
        #(rhalf);
        if (rclk_run) rclk = ~rclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Single write attempt, returning #1 after the sampling edge
    task automatic wr(input logic [7:0] v);
        @(negedge wclk);
        wen     = 1'b1;
        data_in = v;
        @(posedge wclk);
        #1;
        wen = 1'b0;
    endtask

    // One read cycle. It is entered at a negedge of rclk with ren already
    // driven, and it leaves at the next negedge.
    task automatic rd_step(input string tag, output bit got);
        bit pe;
        pe = empty;
        @(posedge rclk);
        #1;
        got = !pe;
        if (got) begin
            chk(tag, {24'd0, data_out}, {24'd0, rexp});
            rexp++;
        end
        @(negedge rclk);
    endtask

    task automatic writer(input int n, input bit until_t);
        int acc;
        bit pf;
        acc   = 0;
        wdone = 1'b0;
        @(negedge wclk);
        for (int c = 0; c < 20000; c++) begin
            if (acc >= n && (!until_t || $time >= 1000)) break;
            wen     = 1'b1;
            data_in = wval;
            pf      = full;
            if (pf) seen_full = 1'b1;
            @(posedge wclk);
            if (!pf) begin
                wval++;
                acc++;
            end
            @(negedge wclk);
        end
        wen   = 1'b0;
        wdone = 1'b1;
    endtask

    task automatic reader(input string tag, input int budget);
        bit got;
        int c;
        c = 0;
        @(negedge rclk);
        ren = 1'b1;
        while (!(wdone && rexp == wval) && c < budget) begin
            if (empty) seen_empty_hi = 1'b1;
            else       seen_empty_lo = 1'b1;
            rd_step(tag, got);
            c++;
        end
        ren = 1'b0;
        chk({tag, "_done"}, {31'd0, (c < budget)}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        int cnt;

        // ---------------- reset ----------------
        #1 reset_n = 1'b0;
        #1;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_dout",  {24'd0, data_out}, 32'd0);
        #4 reset_n = 1'b1;
        repeat (3) @(posedge wclk);
        #1;
        chk("idle_empty", {31'd0, empty}, 32'd1);
        chk("idle_full",  {31'd0, full},  32'd0);
        chk("idle_dout",  {24'd0, data_out}, 32'd0);

        // ---------------- fill (reader clock idle) ----------------
        for (int i = 1; i <= 32; i++) begin
            wr(i[7:0]);
            if (i == 31) chk("full_at_31", {31'd0, full}, 32'd0);
        end
        chk("full_at_32", {31'd0, full}, 32'd1);
        wr(8'd33);
        chk("full_after_33", {31'd0, full}, 32'd1);

        // ---------------- drain ----------------
        rhalf    = 5.0;
        rclk_run = 1'b1;
        @(negedge rclk);
        ren  = 1'b1;
        rexp = 8'd1;
        cnt  = 0;
        for (int c = 0; c < 100 && cnt < 32; c++) begin
            rd_step("drain_data", got);
            if (got) cnt++;
        end
        chk("drain_count", cnt, 32'd32);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_last",  {24'd0, data_out}, 32'd32);
        for (int c = 0; c < 3; c++) begin
            rd_step("drain_extra", got);
        end
        chk("drain_hold", {24'd0, data_out}, 32'd32);
        chk("drain_empty_hold", {31'd0, empty}, 32'd1);
        ren = 1'b0;
        repeat (6) @(posedge wclk);
        #1;
        chk("full_released", {31'd0, full}, 32'd0);

        // ---------------- fast reader: wclk 10 ns, rclk 5 ns ----------------
        whalf         = 5.0;
        rhalf         = 2.5;
        wval          = 8'h40;
        rexp          = 8'h40;
        seen_full     = 1'b0;
        seen_empty_hi = 1'b0;
        seen_empty_lo = 1'b0;
        wdone         = 1'b0;
        fork
            writer(10, 1'b1);
            reader("fast_rd", 4000);
        join
        chk("fast_no_full", {31'd0, seen_full}, 32'd0);
        chk("fast_empty_toggle", {31'd0, seen_empty_hi & seen_empty_lo}, 32'd1);

        // ---------------- swapped clocks: wclk 5 ns, rclk 10 ns -------------
        whalf     = 2.5;
        rhalf     = 5.0;
        seen_full = 1'b0;
        wdone     = 1'b0;
        fork
            writer(150, 1'b0);
            reader("swap_rd", 4000);
        join
        chk("swap_full_seen", {31'd0, seen_full}, 32'd1);
        chk("swap_empty_end", {31'd0, empty}, 32'd1);

        // ---------------- mid-stream reset ----------------
        for (int i = 0; i < 10; i++) begin
            wr(8'h10 + i[7:0]);
        end
        repeat (4) @(posedge rclk);
        #1;
        chk("pre_rst_empty", {31'd0, empty}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_full",  {31'd0, full},  32'd0);
        chk("mid_rst_dout",  {24'd0, data_out}, 32'd0);
        #2 reset_n = 1'b1;
        wr(8'hA5);
        rexp  = 8'hA5;
        wval  = 8'hA6;
        wdone = 1'b1;
        reader("rst_rd", 100);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);
        chk("post_rst_dout",  {24'd0, data_out}, 32'hA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
